pipeline_ctrl: RTL and testbench

- Central stall/flush sequencer for the 5-stage RV32I pipeline.
- Inputs:
  - the combinational stall from the load-use/branch hazard detector;
  - taken-branch resolution in ID;
  - instruction-memory and data-memory ready handshakes.
- Produces per-stage register write-enables and bubble/flush controls and the PC-select.
- Tracks multi-cycle memory waits with a watchdog and keeps stall/flush performance counters.

---
 rtl/pipeline_ctrl.sv | 145 ++++++++++++++
 tb/tb_pipeline_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush sequencer for the 5-stage RV32I pipeline.
// Memory-wait watchdog plus saturating stall/flush counters.
module pipeline_ctrl #(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             hazard_stall_i,
   input  logic             branch_taken_i,
   input  logic             imem_ready_i,
   input  logic             dmem_req_i,
   input  logic             dmem_ready_i,
   output logic             pc_we_o,
   output logic             pc_sel_o,
   output logic             if_id_we_o,
   output logic             if_id_flush_o,
   output logic             id_ex_we_o,
   output logic             id_ex_flush_o,
   output logic             ex_mem_we_o,
   output logic             mem_wb_flush_o,
   output logic             err_o,
   output logic [CNT_W-1:0] stall_cnt_o,
   output logic [CNT_W-1:0] flush_cnt_o
);

   typedef enum logic [1:0] {
      RUN,
      MEM_WAIT,
      IF_WAIT,
      ERROR
   } state_t;

   localparam int WC_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [WC_W-1:0] WC_LAST = WC_W'(TIMEOUT - 1);

   state_t          state;
   logic [WC_W-1:0] wait_cnt;
   logic            mem_freeze;
   logic            if_miss;

   assign mem_freeze = dmem_req_i & ~dmem_ready_i;
   // fetch miss only counts when nothing stronger owns the cycle
   assign if_miss = ~imem_ready_i & ~hazard_stall_i & ~branch_taken_i;

   always_comb begin
      pc_we_o        = 1'b1;
      pc_sel_o       = 1'b0;
      if_id_we_o     = 1'b1;
      if_id_flush_o  = 1'b0;
      id_ex_we_o     = 1'b1;
      id_ex_flush_o  = 1'b0;
      ex_mem_we_o    = 1'b1;
      mem_wb_flush_o = 1'b0;
      if (!rst_n) begin
         pc_we_o        = 1'b0;
         if_id_we_o     = 1'b0;
         id_ex_we_o     = 1'b0;
         ex_mem_we_o    = 1'b0;
         if_id_flush_o  = 1'b1;
         id_ex_flush_o  = 1'b1;
         mem_wb_flush_o = 1'b1;
      end else if (state == ERROR) begin
         pc_we_o     = 1'b0;
         if_id_we_o  = 1'b0;
         id_ex_we_o  = 1'b0;
         ex_mem_we_o = 1'b0;
      end else if (mem_freeze) begin
         pc_we_o        = 1'b0;
         if_id_we_o     = 1'b0;
         id_ex_we_o     = 1'b0;
         ex_mem_we_o    = 1'b0;
         mem_wb_flush_o = 1'b1;
      end else if (hazard_stall_i) begin
         pc_we_o       = 1'b0;
         if_id_we_o    = 1'b0;
         id_ex_flush_o = 1'b1;
      end else if (branch_taken_i) begin
         pc_sel_o      = 1'b1;
         if_id_flush_o = 1'b1;
      end else if (!imem_ready_i) begin
         pc_we_o       = 1'b0;
         if_id_flush_o = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= RUN;
         wait_cnt    <= '0;
         err_o       <= 1'b0;
         stall_cnt_o <= '0;
         flush_cnt_o <= '0;
      end else begin
         if (state != ERROR) begin
            if (!pc_we_o && stall_cnt_o != '1)
               stall_cnt_o <= stall_cnt_o + CNT_W'(1);
            if (pc_sel_o && flush_cnt_o != '1)
               flush_cnt_o <= flush_cnt_o + CNT_W'(1);
         end
         unique case (state)
            RUN: begin
               if (mem_freeze) begin
                  state    <= MEM_WAIT;
                  wait_cnt <= '0;
               end else if (if_miss) begin
                  state    <= IF_WAIT;
                  wait_cnt <= '0;
               end
            end
            MEM_WAIT: begin
               if (!mem_freeze) begin
                  state    <= RUN;
                  wait_cnt <= '0;
               end else if (wait_cnt == WC_LAST) begin
                  state    <= ERROR;
                  wait_cnt <= '0;
                  err_o    <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + WC_W'(1);
               end
            end
            IF_WAIT: begin
               if (mem_freeze) begin
                  state    <= MEM_WAIT;
                  wait_cnt <= '0;
               end else if (imem_ready_i) begin
                  state    <= RUN;
                  wait_cnt <= '0;
               end else if (wait_cnt == WC_LAST) begin
                  state    <= ERROR;
                  wait_cnt <= '0;
                  err_o    <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + WC_W'(1);
               end
            end
            ERROR: begin
               state <= ERROR;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: two instances (default and TIMEOUT=4/CNT_W=4)
// driven in parallel, checked against a behavioural model.
module tb_pipeline_ctrl;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic hazard_stall = 1'b0;
   logic branch_taken = 1'b0;
   logic imem_ready = 1'b1;
   logic dmem_req = 1'b0;
   logic dmem_ready = 1'b0;

   logic b_pc_we, b_pc_sel, b_if_id_we, b_if_id_flush;
   logic b_id_ex_we, b_id_ex_flush, b_ex_mem_we, b_mem_wb_flush;
   logic b_err;
   logic [15:0] b_stall, b_flush;

   logic s_pc_we, s_pc_sel, s_if_id_we, s_if_id_flush;
   logic s_id_ex_we, s_id_ex_flush, s_ex_mem_we, s_mem_wb_flush;
   logic s_err;
   logic [3:0] s_stall, s_flush;

   always #5 clk = ~clk;

   pipeline_ctrl u_big (
      .clk            (clk),
      .rst_n          (rst_n),
      .hazard_stall_i (hazard_stall),
      .branch_taken_i (branch_taken),
      .imem_ready_i   (imem_ready),
      .dmem_req_i     (dmem_req),
      .dmem_ready_i   (dmem_ready),
      .pc_we_o        (b_pc_we),
      .pc_sel_o       (b_pc_sel),
      .if_id_we_o     (b_if_id_we),
      .if_id_flush_o  (b_if_id_flush),
      .id_ex_we_o     (b_id_ex_we),
      .id_ex_flush_o  (b_id_ex_flush),
      .ex_mem_we_o    (b_ex_mem_we),
      .mem_wb_flush_o (b_mem_wb_flush),
      .err_o          (b_err),
      .stall_cnt_o    (b_stall),
      .flush_cnt_o    (b_flush)
   );

   pipeline_ctrl #(.TIMEOUT(4), .CNT_W(4)) u_small (
      .clk            (clk),
      .rst_n          (rst_n),
      .hazard_stall_i (hazard_stall),
      .branch_taken_i (branch_taken),
      .imem_ready_i   (imem_ready),
      .dmem_req_i     (dmem_req),
      .dmem_ready_i   (dmem_ready),
      .pc_we_o        (s_pc_we),
      .pc_sel_o       (s_pc_sel),
      .if_id_we_o     (s_if_id_we),
      .if_id_flush_o  (s_if_id_flush),
      .id_ex_we_o     (s_id_ex_we),
      .id_ex_flush_o  (s_id_ex_flush),
      .ex_mem_we_o    (s_ex_mem_we),
      .mem_wb_flush_o (s_mem_wb_flush),
      .err_o          (s_err),
      .stall_cnt_o    (s_stall),
      .flush_cnt_o    (s_flush)
   );

   int n_chk = 0;
   int n_fail = 0;

   // model: 0 = running, 1 = waiting on dmem, 2 = waiting on imem
   bit merr[2];
   int mwait[2];
   int mcyc[2];
   int mstall[2];
   int mflush[2];
   int to_cyc[2] = '{16, 4};
   int cmax[2] = '{65535, 15};

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp,
                  $time);
      end
   endtask

   // {pc_we, pc_sel, if_id_we, if_id_flush,
   //  id_ex_we, id_ex_flush, ex_mem_we, mem_wb_flush}
   function automatic logic [7:0] exp_ctl(input bit err, input bit hz,
                                          input bit br, input bit im,
                                          input bit rq, input bit rd);
      if (err) return 8'b0000_0000;
      if (rq && !rd) return 8'b0000_0001;
      if (hz) return 8'b0000_1110;
      if (br) return 8'b1111_1010;
      if (!im) return 8'b0011_1010;
      return 8'b1010_1010;
   endfunction

   function automatic logic [7:0] obs_ctl(input int k);
      if (k == 0)
         return {b_pc_we, b_pc_sel, b_if_id_we, b_if_id_flush,
                 b_id_ex_we, b_id_ex_flush, b_ex_mem_we, b_mem_wb_flush};
      return {s_pc_we, s_pc_sel, s_if_id_we, s_if_id_flush,
              s_id_ex_we, s_id_ex_flush, s_ex_mem_we, s_mem_wb_flush};
   endfunction

   function automatic logic [31:0] obs_err(input int k);
      return (k == 0) ? 32'(b_err) : 32'(s_err);
   endfunction

   function automatic logic [31:0] obs_stall(input int k);
      return (k == 0) ? 32'(b_stall) : 32'(s_stall);
   endfunction

   function automatic logic [31:0] obs_flush(input int k);
      return (k == 0) ? 32'(b_flush) : 32'(s_flush);
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         merr[k] = 0;
         mwait[k] = 0;
         mcyc[k] = 0;
         mstall[k] = 0;
         mflush[k] = 0;
      end
   endtask

   task automatic compare_all();
      logic [7:0] c;
      for (int k = 0; k < 2; k++) begin
         c = exp_ctl(merr[k], hazard_stall, branch_taken, imem_ready,
                     dmem_req, dmem_ready);
         check($sformatf("ctl%0d", k), 32'(obs_ctl(k)), 32'(c));
         check($sformatf("err%0d", k), obs_err(k), 32'(merr[k]));
         check($sformatf("stall%0d", k), obs_stall(k), 32'(mstall[k]));
         check($sformatf("flush%0d", k), obs_flush(k), 32'(mflush[k]));
      end
   endtask

   task automatic model_adv();
      logic [7:0] c;
      bit fz;
      fz = dmem_req && !dmem_ready;
      for (int k = 0; k < 2; k++) begin
         c = exp_ctl(merr[k], hazard_stall, branch_taken, imem_ready,
                     dmem_req, dmem_ready);
         if (!merr[k]) begin
            if (!c[7] && mstall[k] < cmax[k]) mstall[k]++;
            if (c[6] && mflush[k] < cmax[k]) mflush[k]++;
            if (mwait[k] == 0) begin
               if (fz) begin
                  mwait[k] = 1; mcyc[k] = 0;
               end else if (!imem_ready && !hazard_stall && !branch_taken) begin
                  mwait[k] = 2; mcyc[k] = 0;
               end
            end else if (mwait[k] == 1) begin
               if (!fz) begin
                  mwait[k] = 0; mcyc[k] = 0;
               end else if (mcyc[k] + 1 == to_cyc[k]) begin
                  merr[k] = 1;
               end else begin
                  mcyc[k]++;
               end
            end else begin
               if (fz) begin
                  mwait[k] = 1; mcyc[k] = 0;
               end else if (imem_ready) begin
                  mwait[k] = 0; mcyc[k] = 0;
               end else if (mcyc[k] + 1 == to_cyc[k]) begin
                  merr[k] = 1;
               end else begin
                  mcyc[k]++;
               end
            end
         end
      end
   endtask

   task automatic step(input bit hz, input bit br, input bit im,
                       input bit rq, input bit rd);
      hazard_stall = hz;
      branch_taken = br;
      imem_ready = im;
      dmem_req = rq;
      dmem_ready = rd;
      @(negedge clk);
      compare_all();
      model_adv();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      #2;
      rst_n = 1'b0;
      #1;
      for (int k = 0; k < 2; k++) begin
         check($sformatf("rst_ctl%0d", k), 32'(obs_ctl(k)), 32'h15);
         check($sformatf("rst_err%0d", k), obs_err(k), 32'd0);
         check($sformatf("rst_stall%0d", k), obs_stall(k), 32'd0);
         check($sformatf("rst_flush%0d", k), obs_flush(k), 32'd0);
      end
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      int fz_left;
      int im_left;
      bit hz, br, im, rq, rd;
      fz_left = 0;
      im_left = 0;
      pulse_reset();

      repeat (5) step(0, 0, 1, 0, 0);
      check("idle_stall", 32'(b_stall), 32'd0);
      check("idle_flush", 32'(b_flush), 32'd0);
      step(1, 0, 1, 0, 0);
      check("hz_stall", 32'(b_stall), 32'd1);
      step(0, 1, 1, 0, 0);
      check("br_flush", 32'(b_flush), 32'd1);
      step(1, 1, 1, 0, 0);
      check("br_masked", 32'(b_flush), 32'd1);
      step(0, 0, 1, 1, 1);
      check("rdy_same", 32'(b_stall), 32'd2);
      repeat (3) step(0, 0, 1, 1, 0);
      step(0, 0, 1, 1, 1);
      check("freeze3", 32'(b_stall), 32'd5);
      step(0, 0, 1, 0, 0);

      repeat (5) step(0, 0, 1, 1, 0);
      check("to_small", 32'(s_err), 32'd1);
      check("to_big", 32'(b_err), 32'd0);
      check("err_stall", 32'(s_stall), 32'd10);
      step(0, 0, 1, 0, 0);
      check("err_ctl", 32'(obs_ctl(1)), 32'd0);
      repeat (12) step(0, 0, 1, 1, 0);
      check("big_wait", 32'(b_err), 32'd0);
      repeat (5) step(0, 0, 1, 1, 0);
      check("big_to", 32'(b_err), 32'd1);
      pulse_reset();

      repeat (5) step(0, 0, 0, 0, 0);
      check("if_to", 32'(s_err), 32'd1);
      pulse_reset();

      repeat (20) step(1, 0, 1, 0, 0);
      check("sat_small", 32'(s_stall), 32'd15);
      check("sat_big", 32'(b_stall), 32'd20);

      for (int i = 0; i < 1500; i++) begin
         if (fz_left == 0 && $urandom_range(0, 99) < 4)
            fz_left = $urandom_range(1, 22);
         if (im_left == 0 && $urandom_range(0, 99) < 4)
            im_left = $urandom_range(1, 20);
         hz = $urandom_range(0, 99) < 12;
         br = $urandom_range(0, 99) < 15;
         im = (im_left > 0) ? 1'b0 : ($urandom_range(0, 99) < 85);
         rq = (fz_left > 0) ? 1'b1 : ($urandom_range(0, 99) < 30);
         rd = (fz_left > 0) ? 1'b0 : ($urandom_range(0, 99) < 60);
         if (fz_left > 0) fz_left--;
         if (im_left > 0) im_left--;
         if ($urandom_range(0, 999) < 8)
            pulse_reset();
         else
            step(hz, br, im, rq, rd);
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
